// File: rtl/mem_bus_xbar_pkg.sv
// Shared definitions for the memory bus crossbar: slave FSM states, index-width helper and
// the address-window decoder.
package mem_bus_xbar_pkg;

    localparam logic S_IDLE = 1'b0;
    localparam logic S_BUSY = 1'b1;

    localparam int unsigned MAX_PORTS = 8;
    localparam int unsigned MAX_AW    = 64;

    typedef struct packed {
        logic [MAX_PORTS-1:0] match;
        logic                 err;
    } dec_result_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Windows are inclusive; scanning downward leaves the lowest matching slave as the winner.
    function automatic dec_result_t decode(
        input logic [MAX_AW-1:0]                  addr,
        input logic [MAX_PORTS-1:0][MAX_AW-1:0]   start_addr,
        input logic [MAX_PORTS-1:0][MAX_AW-1:0]   end_addr,
        input int unsigned                        nb_slave
    );
        dec_result_t r;
        r.match = '0;
        r.err   = 1'b1;
        for (int s = int'(MAX_PORTS) - 1; s >= 0; s--) begin
            if (s < int'(nb_slave) && start_addr[s] <= addr && addr <= end_addr[s]) begin
                r.match    = '0;
                r.match[s] = 1'b1;
                r.err      = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_bus_xbar_rr_arb.sv
// Round-robin arbiter: rotate the request vector by the pointer, take the lowest set bit,
// then rotate the winning position back into master index space.
module mem_bus_xbar_rr_arb
    import mem_bus_xbar_pkg::*;
#(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    localparam int NI = int'(N);

    logic [N-1:0] rot;
    int           pos;

    always_comb begin
        rot   = '0;
        pos   = 0;
        valid = 1'b0;
        for (int i = 0; i < NI; i++) begin
            rot[i] = req[(i + int'(ptr)) % NI];
        end
        for (int i = 0; i < NI; i++) begin
            if (rot[i] && !valid) begin
                valid = 1'b1;
                pos   = i;
            end
        end
        idx = IW'((pos + int'(ptr)) % NI);
        gnt = '0;
        if (valid) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_xbar.sv
// Request/response crossbar between NB_MASTER masters and NB_SLAVE targets with runtime address
// windows, per-slave round-robin arbitration and one outstanding transaction per slave.
module mem_bus_xbar
    import mem_bus_xbar_pkg::*;
#(
    parameter int unsigned NB_MASTER  = 3,
    parameter int unsigned NB_SLAVE   = 3,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NB_MASTER-1:0]                  m_req_i,
    input  logic [NB_MASTER-1:0][ADDR_WIDTH-1:0]  m_addr_i,
    input  logic [NB_MASTER-1:0]                  m_we_i,
    input  logic [NB_MASTER-1:0][DATA_WIDTH/8-1:0] m_be_i,
    input  logic [NB_MASTER-1:0][DATA_WIDTH-1:0]  m_wdata_i,
    output logic [NB_MASTER-1:0]                  m_gnt_o,
    output logic [NB_MASTER-1:0]                  m_rvalid_o,
    output logic [NB_MASTER-1:0][DATA_WIDTH-1:0]  m_rdata_o,
    output logic [NB_MASTER-1:0]                  m_err_o,
    output logic [NB_SLAVE-1:0]                   s_req_o,
    output logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0]   s_addr_o,
    output logic [NB_SLAVE-1:0]                   s_we_o,
    output logic [NB_SLAVE-1:0][DATA_WIDTH/8-1:0] s_be_o,
    output logic [NB_SLAVE-1:0][DATA_WIDTH-1:0]   s_wdata_o,
    input  logic [NB_SLAVE-1:0]                   s_gnt_i,
    input  logic [NB_SLAVE-1:0]                   s_rvalid_i,
    input  logic [NB_SLAVE-1:0][DATA_WIDTH-1:0]   s_rdata_i,
    input  logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0]   start_addr_i,
    input  logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0]   end_addr_i
);

    localparam int unsigned MW = idx_width(NB_MASTER);

    logic [MAX_PORTS-1:0][MAX_AW-1:0]     start_w, end_w;
    logic [NB_MASTER-1:0][NB_SLAVE-1:0]   dec_match;
    logic [NB_MASTER-1:0]                 dec_err, req_eff;
    logic [NB_MASTER-1:0]                 pending_q, pending_d, err_q, err_d;
    logic [NB_SLAVE-1:0]                  state_q, state_d;
    logic [NB_SLAVE-1:0][MW-1:0]          owner_q, owner_d, rr_q, rr_d;
    logic [NB_SLAVE-1:0][NB_MASTER-1:0]   slv_req, slv_gnt;
    logic [NB_SLAVE-1:0][MW-1:0]          win_idx;
    logic [NB_SLAVE-1:0]                  win_valid, accept;

    always_comb begin
        start_w = '0;
        end_w   = '0;
        for (int s = 0; s < int'(NB_SLAVE); s++) begin
            start_w[s] = MAX_AW'(start_addr_i[s]);
            end_w[s]   = MAX_AW'(end_addr_i[s]);
        end
    end

    // A pending master is invisible to arbitration and to the decode-error path.
    always_comb begin
        dec_result_t res;
        res       = '0;
        dec_match = '0;
        dec_err   = '0;
        req_eff   = m_req_i & ~pending_q;
        for (int m = 0; m < int'(NB_MASTER); m++) begin
            res          = decode(MAX_AW'(m_addr_i[m]), start_w, end_w, NB_SLAVE);
            dec_match[m] = res.match[NB_SLAVE-1:0];
            dec_err[m]   = res.err;
        end
    end

    always_comb begin
        slv_req = '0;
        for (int s = 0; s < int'(NB_SLAVE); s++) begin
            for (int m = 0; m < int'(NB_MASTER); m++) begin
                slv_req[s][m] = req_eff[m] & dec_match[m][s];
            end
        end
    end

    for (genvar gs = 0; gs < NB_SLAVE; gs++) begin : g_arb
        mem_bus_xbar_rr_arb #(
            .N  (NB_MASTER),
            .IW (MW)
        ) u_arb (
            .req   (slv_req[gs]),
            .ptr   (rr_q[gs]),
            .gnt   (slv_gnt[gs]),
            .idx   (win_idx[gs]),
            .valid (win_valid[gs])
        );
    end

    always_comb begin
        s_req_o   = '0;
        s_addr_o  = '0;
        s_we_o    = '0;
        s_be_o    = '0;
        s_wdata_o = '0;
        accept    = '0;
        for (int s = 0; s < int'(NB_SLAVE); s++) begin
            if (state_q[s] == S_IDLE && win_valid[s]) begin
                s_req_o[s]   = 1'b1;
                s_addr_o[s]  = m_addr_i[win_idx[s]];
                s_we_o[s]    = m_we_i[win_idx[s]];
                s_be_o[s]    = m_be_i[win_idx[s]];
                s_wdata_o[s] = m_wdata_i[win_idx[s]];
            end
            accept[s] = s_req_o[s] & s_gnt_i[s];
        end
    end

    always_comb begin
        m_gnt_o    = req_eff & dec_err;
        m_rvalid_o = err_q;
        m_err_o    = err_q;
        m_rdata_o  = '0;
        for (int s = 0; s < int'(NB_SLAVE); s++) begin
            if (accept[s]) begin
                m_gnt_o = m_gnt_o | slv_gnt[s];
            end
            if (state_q[s] == S_BUSY && s_rvalid_i[s]) begin
                m_rvalid_o[owner_q[s]] = 1'b1;
                m_rdata_o[owner_q[s]]  = s_rdata_i[s];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        for (int s = 0; s < int'(NB_SLAVE); s++) begin
            if (state_q[s] == S_IDLE) begin
                if (accept[s]) begin
                    state_d[s] = S_BUSY;
                    owner_d[s] = win_idx[s];
                    rr_d[s]    = (int'(win_idx[s]) + 1 >= int'(NB_MASTER)) ? '0
                                                                           : win_idx[s] + MW'(1);
                end
            end else if (s_rvalid_i[s]) begin
                state_d[s] = S_IDLE;
            end
        end
        pending_d = (pending_q & ~m_rvalid_o) | m_gnt_o;
        err_d     = req_eff & dec_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= '0;
            owner_q   <= '0;
            rr_q      <= '0;
            pending_q <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: doc/mem_bus_xbar.md
# mem_bus_xbar

Parametrised request/response crossbar connecting NB_MASTER core-side masters (core data port, debug, DMA/SPI) to NB_SLAVE memory-mapped targets (instruction RAM, data RAM, peripheral bridge), using the core's req/gnt/rvalid protocol. It generalises the fixed 3×3 system interconnect with:
- runtime address windows;
- per-slave round-robin arbitration;
- one outstanding transaction per slave;
- decode-error responses for unmapped addresses.

## Interface
Parameters:
- NB_MASTER, 3, number of master ports (1..8)
- NB_SLAVE, 3, number of slave ports (1..8)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; BE width is DATA_WIDTH/8

Ports:
- clk  in  1  single clock
- rst  in  1  reset, asynchronous and active-high
- m_req_i  in  [NB_MASTER]  master request
- m_addr_i  in  [NB_MASTER][ADDR_WIDTH]  byte address
- m_we_i  in  [NB_MASTER]  1 = write
- m_be_i  in  [NB_MASTER][DATA_WIDTH/8]  byte enables
- m_wdata_i  in  [NB_MASTER][DATA_WIDTH]  write data
- m_gnt_o  out  [NB_MASTER]  request accepted
- m_rvalid_o  out  [NB_MASTER]  response valid
- m_rdata_o  out  [NB_MASTER][DATA_WIDTH]  read data
- m_err_o  out  [NB_MASTER]  decode error, qualified by m_rvalid_o
- s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o  out  [NB_SLAVE][...]  slave-side copies of the above
- s_gnt_i  in  [NB_SLAVE]  slave accepts
- s_rvalid_i  in  [NB_SLAVE]  slave response
- s_rdata_i  in  [NB_SLAVE][DATA_WIDTH]  slave read data
- start_addr_i, end_addr_i  in  [NB_SLAVE][ADDR_WIDTH]  inclusive address window per slave; quasi-static

## Operation
- **Decode:** master m targets slave s when start_addr_i[s] ≤ m_addr_i[m] ≤ end_addr_i[s]. If windows overlap, the lowest s wins. No match means a decode error.
- **Per-slave FSM, IDLE → BUSY → IDLE:**
  - Slave registers: owner (master index) and rr_ptr.
  - In IDLE, the arbiter picks the first requesting master targeting s, searching from rr_ptr upward modulo NB_MASTER.
  - The winner's fields drive s_*_o with s_req_o = 1. All other slaves drive s_req_o = 0 and hold fields at 0.
  - s_gnt_i propagates combinationally to the winner's m_gnt_o. On that edge: go to BUSY, owner = winner, rr_ptr = winner+1 mod NB_MASTER.
  - In BUSY, s_req_o = 0.
  - s_rvalid_i drives m_rvalid_o[owner] = 1, m_rdata_o[owner] = s_rdata_i[s], m_err_o = 0, and the FSM returns to IDLE.
- **Per-master pending flag:**
  - Set on m_gnt_o; cleared on m_rvalid_o.
  - While pending, m_req_i is masked: no arbitration, no m_gnt_o.
- **Decode error path:**
  - Unmapped request from a non-pending master gets m_gnt_o = 1 in the same cycle.
  - Next cycle: m_rvalid_o = 1, m_err_o = 1, m_rdata_o = 0.
  - No slave sees the request.
- **Response mux:** masters with no response have m_rvalid_o = 0 and m_rdata_o = 0.
- **Protocol violations:** s_rvalid_i while IDLE is ignored. s_gnt_i without s_req_o is ignored.

## Timing
- Request path is combinational: m_req_i → s_req_o → s_gnt_i → m_gnt_o in the same cycle.
- Response path is combinational: s_rvalid_i → m_rvalid_o in the same cycle.
- Minimum response latency is one cycle after grant, since slaves respond no earlier than the cycle after gnt.
- Decode error response is exactly one cycle after grant.
- A slave returning to IDLE on an rvalid edge can grant a new request in the next cycle, not the same cycle. Back-to-back throughput per slave: one transaction per 2 cycles.
- A master can re-request in the cycle after its m_rvalid_o.
- **Reset values:**
  - All FSMs IDLE, owner = 0, rr_ptr = 0, pending = 0, error flags = 0.
  - With inputs idle, all outputs are 0.
- **Reset mid-transaction:** state clears immediately and in-flight responses are dropped. A late s_rvalid_i after reset is ignored because the slave is IDLE.
- **Simultaneous requests to different slaves:** granted in parallel.
- **Same master, same cycle:** its pending flag is cleared by rvalid and it may not be granted again until the following cycle.

## Structure
- Package mem_bus_xbar_pkg holds:
  - slave state enum (S_IDLE, S_BUSY);
  - localparam index widths $clog2(NB_MASTER) and $clog2(NB_SLAVE), minimum 1;
  - decode function (address plus windows → match vector plus error).
- Sub-module mem_bus_xbar_rr_arb, instantiated once per slave:
  - NB_MASTER-wide request vector plus rr_ptr → one-hot grant plus index;
  - rotate, priority-encode, rotate back.

## Test plan
- **Single read:** M0 reads 0x0000_0010 (slave 0, window 0x0–0x000F_FFFF). Slave gnt same cycle, rvalid +2 with 0xDEADBEEF. Required: M0 sees gnt in the req cycle, then rvalid with rdata 0xDEADBEEF, err = 0.
- **Round-robin:** M0, M1, M2 hold req to slave 2 continuously; slave responds 1 cycle after gnt. Required: grant order M0, M1, M2, M0, one grant every 2 cycles.
- **Decode error:** M1 reads 0x8000_0000. Required: gnt same cycle, rvalid + err + rdata = 0 next cycle, all s_req_o = 0.
- **Parallel access:** M0 → slave 0 and M1 → slave 1 in the same cycle. Required: both granted that cycle, both responses delivered independently.
- **Reset mid-transaction:** rst pulsed while slave 1 is BUSY; a late s_rvalid_i[1] arrives after reset. Required: no m_rvalid_o, and the next request is granted normally.
- **Pending mask:** M0 holds req after grant. Required: no second gnt until the cycle after its rvalid; the overlap window address maps to the lower slave index.
